// File: rtl/jt900h_cregs.sv
// TLCS-900H control register file: micro-DMA channel registers and INTNEST.
// Reads are combinational; writes and DMA-step/nesting updates commit on cen.
module jt900h_cregs #(
    parameter int DMA_CH = 4
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic [7:0]  cra,
    input  logic [31:0] crin,
    input  logic        cr_we,
    input  logic [7:0]  rd_addr,
    output logic [31:0] cr,
    input  logic [1:0]  dma_ch,
    input  logic        dma_step,
    output logic [23:0] dma_src,
    output logic [23:0] dma_dst,
    output logic [1:0]  dma_size,
    output logic [3:0]  dma_end,
    input  logic        nest_inc,
    input  logic        nest_dec,
    output logic [15:0] intnest
);

    logic [31:0] r_dmas [0:3];
    logic [31:0] r_dmad [0:3];
    logic [15:0] r_dmac [0:3];
    logic [4:0]  r_dmam [0:3];
    logic [3:0]  r_end;
    logic [15:0] r_nest;

    logic [31:0] w_dmas_nx [0:3];
    logic [31:0] w_dmad_nx [0:3];
    logic [15:0] w_dmac_nx [0:3];
    logic [4:0]  w_dmam_nx [0:3];
    logic [3:0]  w_end_nx;
    logic [15:0] w_nest_nx;

    // Unimplemented channels never see a write or step, so they stay at reset zero.
    always_comb begin
        logic [31:0] w_d;
        logic [2:0]  w_m;
        logic        w_step;
        logic        w_wr_c;
        for (int n = 0; n < 4; n++) begin
            w_dmas_nx[n] = r_dmas[n];
            w_dmad_nx[n] = r_dmad[n];
            w_dmac_nx[n] = r_dmac[n];
            w_dmam_nx[n] = r_dmam[n];
            w_end_nx[n]  = 1'b0;
            w_step = dma_step && (dma_ch == 2'(n));
            w_wr_c = cr_we && (cra == 8'(8'h20 + n * 4));
            w_m    = r_dmam[n][4:2];
            case (r_dmam[n][1:0])
                2'd0:    w_d = 32'd1;
                2'd1:    w_d = 32'd2;
                default: w_d = 32'd4;
            endcase
            if (n < DMA_CH) begin
                if (w_step) begin
                    case (w_m)
                        3'd0: w_dmad_nx[n] = r_dmad[n] + w_d;
                        3'd1: w_dmad_nx[n] = r_dmad[n] - w_d;
                        3'd2: w_dmas_nx[n] = r_dmas[n] + w_d;
                        3'd3: w_dmas_nx[n] = r_dmas[n] - w_d;
                        3'd5: w_dmas_nx[n] = r_dmas[n] + 32'd1;
                        default: ;
                    endcase
                    w_dmac_nx[n] = r_dmac[n] - 16'd1;
                    w_end_nx[n]  = !w_wr_c && (r_dmac[n] == 16'd1);
                end
                // A CPU write to the same register overrides the step result.
                if (cr_we && cra == 8'(n * 4))          w_dmas_nx[n] = crin;
                if (cr_we && cra == 8'(8'h10 + n * 4))  w_dmad_nx[n] = crin;
                if (w_wr_c)                             w_dmac_nx[n] = crin[15:0];
                if (cr_we && cra == 8'(8'h22 + n * 4))  w_dmam_nx[n] = crin[4:0];
            end
        end
    end

    always_comb begin
        w_nest_nx = r_nest;
        if (cr_we && cra == 8'h3C)
            w_nest_nx = crin[15:0];
        else if (nest_inc && !nest_dec)
            w_nest_nx = r_nest + 16'd1;
        else if (nest_dec && !nest_inc)
            w_nest_nx = r_nest - 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                r_dmas[n] <= '0;
                r_dmad[n] <= '0;
                r_dmac[n] <= '0;
                r_dmam[n] <= '0;
            end
            r_end  <= '0;
            r_nest <= '0;
        end else if (cen) begin
            for (int n = 0; n < 4; n++) begin
                r_dmas[n] <= w_dmas_nx[n];
                r_dmad[n] <= w_dmad_nx[n];
                r_dmac[n] <= w_dmac_nx[n];
                r_dmam[n] <= w_dmam_nx[n];
            end
            r_end  <= w_end_nx;
            r_nest <= w_nest_nx;
        end
    end

    always_comb begin
        cr = '0;
        case (rd_addr[7:4])
            4'h0: if (rd_addr[1:0] == 2'd0) cr = r_dmas[rd_addr[3:2]];
            4'h1: if (rd_addr[1:0] == 2'd0) cr = r_dmad[rd_addr[3:2]];
            4'h2: begin
                if (rd_addr[1:0] == 2'd0)
                    cr = {16'd0, r_dmac[rd_addr[3:2]]};
                else if (rd_addr[1:0] == 2'd2)
                    cr = {27'd0, r_dmam[rd_addr[3:2]]};
            end
            4'h3: if (rd_addr == 8'h3C) cr = {16'd0, r_nest};
            default: ;
        endcase
    end

    assign dma_src  = r_dmas[dma_ch][23:0];
    assign dma_dst  = r_dmad[dma_ch][23:0];
    assign dma_size = r_dmam[dma_ch][1:0];
    assign dma_end  = r_end;
    assign intnest  = r_nest;

endmodule

// File: tb/tb_jt900h_cregs.sv
// Directed bench for jt900h_cregs: a 4-channel and a 2-channel instance share stimulus.
module tb_jt900h_cregs;

    logic        rst, clk, cen;
    logic [7:0]  cra, rd_addr;
    logic [31:0] crin;
    logic        cr_we, dma_step, nest_inc, nest_dec;
    logic [1:0]  dma_ch;
    logic [31:0] cr, cr2;
    logic [23:0] dma_src, dma_dst, dma_src2, dma_dst2;
    logic [1:0]  dma_size, dma_size2;
    logic [3:0]  dma_end, dma_end2;
    logic [15:0] intnest, intnest2;

    int checks = 0;
    int failures = 0;

    jt900h_cregs #(.DMA_CH(4)) u_dut (
        .rst(rst), .clk(clk), .cen(cen), .cra(cra), .crin(crin), .cr_we(cr_we),
        .rd_addr(rd_addr), .cr(cr), .dma_ch(dma_ch), .dma_step(dma_step),
        .dma_src(dma_src), .dma_dst(dma_dst), .dma_size(dma_size), .dma_end(dma_end),
        .nest_inc(nest_inc), .nest_dec(nest_dec), .intnest(intnest)
    );

    jt900h_cregs #(.DMA_CH(2)) u_dut2 (
        .rst(rst), .clk(clk), .cen(cen), .cra(cra), .crin(crin), .cr_we(cr_we),
        .rd_addr(rd_addr), .cr(cr2), .dma_ch(dma_ch), .dma_step(dma_step),
        .dma_src(dma_src2), .dma_dst(dma_dst2), .dma_size(dma_size2), .dma_end(dma_end2),
        .nest_inc(nest_inc), .nest_dec(nest_dec), .intnest(intnest2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        cra = a; crin = d; cr_we = 1'b1;
        tick();
        cr_we = 1'b0;
    endtask

    task automatic step(input logic [1:0] ch);
        dma_ch = ch; dma_step = 1'b1;
        tick();
        dma_step = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] v, output logic [31:0] v2);
        rd_addr = a;
        #1;
        v = cr;
        v2 = cr2;
    endtask

    task automatic expect32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset;
        logic [7:0]  addrs [21];
        logic [31:0] v, v2;
        addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C,
                  8'h20, 8'h24, 8'h28, 8'h2C, 8'h22, 8'h26, 8'h2A, 8'h2E,
                  8'h3C, 8'h30, 8'h01, 8'h21, 8'hFF};
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 21; i++) begin
            rd(addrs[i], v, v2);
            checks++;
            if (v !== 32'd0) begin
                failures++;
                $display("FAIL reset_read[%h]: got %h expected 0", addrs[i], v);
            end
        end
        checks++;
        if (dma_end !== 4'd0 || intnest !== 16'd0) begin
            failures++;
            $display("FAIL reset_outputs: dma_end=%h intnest=%h expected 0/0", dma_end, intnest);
        end
    endtask

    task automatic test_write;
        logic [31:0] v, v2;
        wr(8'h00, 32'h12345678);
        rd(8'h00, v, v2);
        expect32("write_dmas0", v, 32'h12345678);
        rd(8'h30, v, v2);
        expect32("read_unmapped_30", v, 32'd0);
        wr(8'h2C, 32'hABCD1234);
        rd(8'h2C, v, v2);
        expect32("dmac3_truncate", v, 32'h00001234);
        wr(8'h2E, 32'hFFFFFFFF);
        rd(8'h2E, v, v2);
        expect32("dmam3_truncate", v, 32'h0000001F);
        wr(8'h30, 32'h55555555);
        rd(8'h30, v, v2);
        expect32("write_unmapped_ignored", v, 32'd0);
    endtask

    task automatic test_dma_dec;
        logic [31:0] v, v2;
        wr(8'h22, 32'h05);
        wr(8'h10, 32'h1000);
        wr(8'h20, 32'd2);
        dma_ch = 2'd0;
        #1;
        expect32("dma_size_ch0", {30'd0, dma_size}, 32'd1);
        step(2'd0);
        expect32("dma_end_after_step1", {28'd0, dma_end}, 32'd0);
        expect32("dma_dst_after_step1", {8'd0, dma_dst}, 32'h0FFE);
        step(2'd0);
        expect32("dma_end_after_step2", {28'd0, dma_end}, 32'h1);
        cen = 1'b0;
        tick();
        expect32("dma_end_frozen", {28'd0, dma_end}, 32'h1);
        cen = 1'b1;
        tick();
        expect32("dma_end_cleared", {28'd0, dma_end}, 32'd0);
        rd(8'h10, v, v2);
        expect32("dmad0_final", v, 32'h0FFC);
        rd(8'h20, v, v2);
        expect32("dmac0_final", v, 32'd0);
    endtask

    task automatic test_counter;
        logic [31:0] v, v2;
        wr(8'h26, 32'h14);
        wr(8'h04, 32'hFFFFFFFF);
        step(2'd1);
        expect32("counter_no_end", {28'd0, dma_end}, 32'd0);
        rd(8'h04, v, v2);
        expect32("dmas1_wrap", v, 32'd0);
        rd(8'h24, v, v2);
        expect32("dmac1_wrap", v, 32'h0000FFFF);
        rd(8'h14, v, v2);
        expect32("dmad1_untouched", v, 32'd0);
    endtask

    task automatic test_back_to_back;
        logic [31:0] v, v2;
        wr(8'h2A, 32'h00);
        wr(8'h28, 32'd5);
        cra = 8'h28; crin = 32'd9; cr_we = 1'b1; dma_ch = 2'd2; dma_step = 1'b1;
        tick();
        cr_we = 1'b0; dma_step = 1'b0;
        rd(8'h28, v, v2);
        expect32("collide_dmac2", v, 32'd9);
        rd(8'h18, v, v2);
        expect32("collide_dmad2", v, 32'd1);
        expect32("collide_no_end", {28'd0, dma_end}, 32'd0);
        wr(8'h28, 32'd1);
        cra = 8'h28; crin = 32'd0; cr_we = 1'b1; dma_step = 1'b1;
        tick();
        cr_we = 1'b0; dma_step = 1'b0;
        expect32("collide_zero_no_end", {28'd0, dma_end}, 32'd0);
        rd(8'h18, v, v2);
        expect32("collide2_dmad2", v, 32'd2);
    endtask

    task automatic test_nest;
        logic [31:0] v, v2;
        nest_inc = 1'b1;
        tick(); tick(); tick();
        nest_dec = 1'b1;
        tick();
        nest_inc = 1'b0;
        tick();
        nest_dec = 1'b0;
        expect32("nest_two", {16'd0, intnest}, 32'd2);
        nest_dec = 1'b1;
        tick(); tick();
        expect32("nest_zero", {16'd0, intnest}, 32'd0);
        tick();
        nest_dec = 1'b0;
        expect32("nest_wrap", {16'd0, intnest}, 32'h0000FFFF);
        cra = 8'h3C; crin = 32'd7; cr_we = 1'b1; nest_inc = 1'b1;
        tick();
        cr_we = 1'b0; nest_inc = 1'b0;
        rd(8'h3C, v, v2);
        expect32("nest_write_wins", v, 32'd7);
    endtask

    task automatic test_two_channels;
        logic [31:0] v, v2;
        wr(8'h08, 32'hAA);
        rd(8'h08, v, v2);
        expect32("ch2_dmas2_wide", v, 32'hAA);
        expect32("ch2_dmas2_absent", v2, 32'd0);
        rd(8'h28, v, v2);
        expect32("ch2_dmac2_absent", v2, 32'd0);
        wr(8'h2E, 32'h01);
        step(2'd3);
        step(2'd3);
        expect32("ch2_no_end", {28'd0, dma_end2}, 32'd0);
        expect32("ch2_src3", {8'd0, dma_src2}, 32'd0);
        rd(8'h0C, v, v2);
        expect32("ch2_dmas3", v2, 32'd0);
        rd(8'h00, v, v2);
        expect32("ch2_dmas0_kept", v2, 32'h12345678);
        rd(8'h10, v, v2);
        expect32("ch2_dmad0_kept", v2, 32'h0FFC);
        rd(8'h24, v, v2);
        expect32("ch2_dmac1_kept", v2, 32'h0000FFFF);
        expect32("ch2_intnest", {16'd0, intnest2}, 32'd7);
    endtask

    task automatic test_reset_mid;
        logic [31:0] v, v2;
        dma_ch = 2'd0; dma_step = 1'b1; nest_inc = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        rd(8'h10, v, v2);
        expect32("midreset_dmad0", v, 32'd0);
        expect32("midreset_intnest", {16'd0, intnest}, 32'd0);
        tick();
        dma_step = 1'b0; nest_inc = 1'b0;
        rst = 1'b0;
        tick();
        rd(8'h00, v, v2);
        expect32("midreset_dmas0", v, 32'd0);
        expect32("midreset_end", {28'd0, dma_end}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; cen = 1'b1; cra = '0; crin = '0; cr_we = 1'b0; rd_addr = '0;
        dma_ch = '0; dma_step = 1'b0; nest_inc = 1'b0; nest_dec = 1'b0;
        test_reset();
        test_write();
        test_dma_dec();
        test_counter();
        test_back_to_back();
        test_nest();
        test_two_channels();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
